math_pow2_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one fixed-latency base-2 antilog unit (12-bit log-domain input, 34-bit linear output with 8 fractional bits) among NREQ requesters. It accepts one request per enabled cycle, drives the unit's data and enable inputs, and tracks each operation through a tag pipeline matched to the unit latency. It returns each result to its originator on a shared data bus with a one-hot valid. It sits between the detection/gain-control clients and the antilog core in the math utility layer.

---
 rtl/math_pow2_arb.sv | 90 +++++++++
 tb/tb_math_pow2_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/math_pow2_arb.sv
// Round-robin arbiter sharing one fixed-latency antilog unit among NREQ
// requesters, with a tag pipeline that routes each result back to its source.
module math_pow2_arb #(
  parameter  int NREQ = 4,
  parameter  int LAT  = 3,
  localparam int IDXW = $clog2(NREQ),
  localparam int IW   = $clog2(LAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [12*NREQ-1:0] req_din,
  output logic [NREQ-1:0]    req_ready,
  output logic               pow_ena,
  output logic [11:0]        pow_din,
  input  logic [33:0]        pow_dout,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [33:0]        rsp_dout,
  output logic [IW-1:0]      inflight,
  output logic               busy
);

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] gidx;
  logic            found;
  logic            accept;
  logic [LAT-1:0]  tag_v;
  logic [IDXW-1:0] tag_i [LAT];
  logic            tail_v;
  logic [IDXW-1:0] tail_i;

  // Search starts at ptr and wraps, so the last winner goes to the back.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gidx  = IDXW'(j);
      end
    end
  end

  assign accept = found & ena & ~rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gidx] = 1'b1;
  end

  assign pow_ena  = ena;
  assign pow_din  = found ? req_din[12*gidx +: 12] : 12'h000;
  assign rsp_dout = pow_dout;

  assign tail_v = tag_v[LAT-1];
  assign tail_i = tag_i[LAT-1];

  always_comb begin
    rsp_valid = '0;
    if (tail_v && ena && !rst) rsp_valid[tail_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      tag_v    <= '0;
      inflight <= '0;
      for (int i = 0; i < LAT; i++) tag_i[i] <= '0;
    end else if (ena) begin
      if (accept) begin
        ptr <= (gidx == IDXW'(NREQ - 1)) ? '0 : gidx + IDXW'(1);
      end
      for (int i = LAT - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_i[i] <= tag_i[i-1];
      end
      tag_v[0] <= accept;
      tag_i[0] <= gidx;
      inflight <= inflight + IW'(accept) - IW'(tail_v);
    end
  end

  assign busy = (inflight != '0) | (|req_valid);

endmodule

// File: tb/tb_math_pow2_arb.sv
// Bench for math_pow2_arb: behavioral antilog unit plus an in-order
// scoreboard of accepted requests matched against response strobes.
module tb_math_pow2_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IW   = $clog2(LAT + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            ena;
  logic [NREQ-1:0] req_valid;
  logic [47:0]     req_din;
  logic [NREQ-1:0] req_ready;
  logic            pow_ena;
  logic [11:0]     pow_din;
  logic [33:0]     pow_dout;
  logic [NREQ-1:0] rsp_valid;
  logic [33:0]     rsp_dout;
  logic [IW-1:0]   inflight;
  logic            busy;

  math_pow2_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .req_valid(req_valid), .req_din(req_din), .req_ready(req_ready),
    .pow_ena(pow_ena), .pow_din(pow_din), .pow_dout(pow_dout),
    .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  // Antilog unit: integer part of the 6-fraction-bit exponent only.
  logic [33:0] upipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) upipe[i] <= '0;
    end else if (pow_ena) begin
      for (int i = LAT - 1; i > 0; i--) upipe[i] <= upipe[i-1];
      upipe[0] <= 34'h100 << pow_din[11:6];
    end
  end
  assign pow_dout = upipe[LAT-1];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          sb_idx [$];
  logic [33:0] sb_dat [$];

  always @(negedge clk) begin
    if (rst) begin
      sb_idx.delete();
      sb_dat.delete();
    end else if (ena) begin
      if (rsp_valid != '0) begin
        if (sb_idx.size() == 0) begin
          chk("rsp_unexp", 64'(rsp_valid), 64'(0));
        end else begin
          int          ei;
          logic [33:0] ed;
          ei = sb_idx.pop_front();
          ed = sb_dat.pop_front();
          chk("rsp_idx", 64'(rsp_valid), 64'(1) << ei);
          chk("rsp_dat", 64'(rsp_dout), 64'(ed));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_idx.push_back(i);
          sb_dat.push_back(34'h100 << req_din[12*i+6 +: 6]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int  g;
    bit  got3;

    rst = 1'b1; ena = 1'b1; req_valid = '0; req_din = '0;
    cyc();
    @(negedge clk);
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_rsp", 64'(rsp_valid), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_busy0", 64'(busy), 64'(0));
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rst_ready_v", 64'(req_ready), 64'(0));
    chk("rst_busy1", 64'(busy), 64'(1));

    // single request from requester 2
    cyc();
    rst = 1'b0;
    req_valid = 4'b0100;
    req_din[35:24] = 12'h040;
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'(4'b0100));
    chk("single_din", 64'(pow_din), 64'(12'h040));
    cyc();
    req_valid = '0;
    repeat (LAT - 1) cyc();
    @(negedge clk);
    chk("single_rsp", 64'(rsp_valid), 64'(4'b0100));
    chk("single_dout", 64'(rsp_dout), 64'(34'h200));
    cyc();

    // all four valid, back to back
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_din = {12'h0C0, 12'h080, 12'h040, 12'h000};
    g = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), 64'(1) << g);
      if (c == 6) chk("inflight_sat", 64'(inflight), 64'(LAT));
      g = (g + 1) % NREQ;
      cyc();
    end

    // stall mid-traffic
    ena = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready", 64'(req_ready), 64'(0));
      chk("stall_rsp", 64'(rsp_valid), 64'(0));
      chk("stall_pow_ena", 64'(pow_ena), 64'(0));
      cyc();
    end
    ena = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("resume_grant", 64'(req_ready), 64'(1) << g);
      g = (g + 1) % NREQ;
      cyc();
    end
    req_valid = '0;
    repeat (LAT + 2) cyc();
    @(negedge clk);
    chk("drain_sb", 64'(sb_idx.size()), 64'(0));
    chk("drain_inflight", 64'(inflight), 64'(0));
    chk("drain_busy", 64'(busy), 64'(0));

    // fairness: 0 always valid, 3 joins
    cyc();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("fair_pre", 64'(req_ready), 64'(4'b0001));
    cyc();
    req_valid = 4'b1001;
    got3 = 1'b0;
    for (int c = 0; c < NREQ; c++) begin
      @(negedge clk);
      if (req_ready[3]) begin
        got3 = 1'b1;
        break;
      end
      cyc();
    end
    chk("fair_grant3", 64'(got3), 64'(1));
    cyc();
    @(negedge clk);
    chk("fair_next", 64'(req_ready), 64'(4'b0001));
    cyc();
    req_valid = '0;
    repeat (LAT + 2) cyc();

    // reset with three tags in flight
    req_valid = 4'b1111;
    repeat (3) cyc();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_inflight", 64'(inflight), 64'(LAT));
    chk("mid_rsp", 64'(rsp_valid), 64'(0));
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_cleared", 64'(inflight), 64'(0));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_pow_din", 64'(pow_din), 64'(0));
      chk("idle_rsp", 64'(rsp_valid), 64'(0));
      cyc();
    end
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_sb", 64'(sb_idx.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
